// File: rtl/alu_issue_station.sv
// ALU reservation station: holds issued ALU ops until both operands are
// available, snoops the CDB for wake-up, and dispatches the oldest ready
// entry into a single registered output stage toward the ALU.
module alu_issue_station #(
  parameter int RS_SIZE = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int CDB_N   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     issue_valid_in,
  input  logic [5:0]               issue_op_in,
  input  logic [31:0]              issue_inst_in,
  input  logic [31:0]              issue_pc_in,
  input  logic [31:0]              issue_imm_in,
  input  logic [TAG_W-1:0]         issue_dest_in,
  input  logic [XLEN-1:0]          issue_vj_in,
  input  logic [XLEN-1:0]          issue_vk_in,
  input  logic                     issue_qj_busy_in,
  input  logic                     issue_qk_busy_in,
  input  logic [TAG_W-1:0]         issue_qj_in,
  input  logic [TAG_W-1:0]         issue_qk_in,
  input  logic [CDB_N-1:0]         cdb_valid_in,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag_in,
  input  logic [CDB_N*XLEN-1:0]    cdb_value_in,
  input  logic                     exec_ready_in,
  output logic                     full_out,
  output logic [$clog2(RS_SIZE):0] count_out,
  output logic                     exec_valid_out,
  output logic [5:0]               exec_op_out,
  output logic [31:0]              exec_inst_out,
  output logic [31:0]              exec_pc_out,
  output logic [31:0]              exec_imm_out,
  output logic [TAG_W-1:0]         exec_dest_out,
  output logic [XLEN-1:0]          exec_vj_out,
  output logic [XLEN-1:0]          exec_vk_out
);

  localparam int IDXW = $clog2(RS_SIZE);
  localparam int CNTW = IDXW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qjBusy;
  logic [RS_SIZE-1:0] r_qkBusy;
  logic [TAG_W-1:0]   r_qj   [RS_SIZE];
  logic [TAG_W-1:0]   r_qk   [RS_SIZE];
  logic [TAG_W-1:0]   r_dest [RS_SIZE];
  logic [XLEN-1:0]    r_vj   [RS_SIZE];
  logic [XLEN-1:0]    r_vk   [RS_SIZE];
  logic [5:0]         r_op   [RS_SIZE];
  logic [31:0]        r_inst [RS_SIZE];
  logic [31:0]        r_pc   [RS_SIZE];
  logic [31:0]        r_imm  [RS_SIZE];
  // r_olderThan[i][j] = 1 means entry j was issued before entry i
  logic [RS_SIZE-1:0] r_olderThan [RS_SIZE];
  logic [CNTW-1:0]    r_count;

  logic               r_execValid;
  logic [5:0]         r_execOp;
  logic [31:0]        r_execInst;
  logic [31:0]        r_execPc;
  logic [31:0]        r_execImm;
  logic [TAG_W-1:0]   r_execDest;
  logic [XLEN-1:0]    r_execVj;
  logic [XLEN-1:0]    r_execVk;

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_win;
  logic [IDXW-1:0]    w_selIdx;
  logic               w_selValid;
  logic [IDXW-1:0]    w_freeIdx;
  logic [RS_SIZE-1:0] w_selfMask;
  logic               w_full;
  logic               w_issueAccept;
  logic               w_canLoad;
  logic               w_dispatch;
  logic [RS_SIZE-1:0] w_jHit;
  logic [RS_SIZE-1:0] w_kHit;
  logic [XLEN-1:0]    w_jVal [RS_SIZE];
  logic [XLEN-1:0]    w_kVal [RS_SIZE];
  logic               w_issJHit;
  logic               w_issKHit;
  logic [XLEN-1:0]    w_issJVal;
  logic [XLEN-1:0]    w_issKVal;

  assign w_ready       = r_busy & ~r_qjBusy & ~r_qkBusy;
  assign w_full        = (r_count == FULL_CNT);
  assign w_issueAccept = issue_valid_in & ~w_full & rdy_in & ~flush_in;
  assign w_canLoad     = ~r_execValid | exec_ready_in;
  assign w_dispatch    = w_canLoad & w_selValid;
  assign w_selValid    = |w_ready;
  assign w_selfMask    = ~(RS_SIZE'(1) << w_freeIdx);

  // An entry wins selection when no other ready entry is older than it
  always_comb begin
    w_win = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_win[i] = w_ready[i] & ~|(w_ready & r_olderThan[i]);
    end
  end

  // Encode the winning entry index; scanning downward keeps the lowest index
  always_comb begin
    w_selIdx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_win[i]) begin
        w_selIdx = IDXW'(i);
      end
    end
  end

  // New instructions go into the lowest-index free slot
  always_comb begin
    w_freeIdx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_freeIdx = IDXW'(i);
      end
    end
  end

  // CDB tag match for every stored operand and for the incoming issue;
  // channels are scanned high to low so the lowest channel wins on duplicates
  always_comb begin
    w_jHit    = '0;
    w_kHit    = '0;
    w_issJHit = 1'b0;
    w_issKHit = 1'b0;
    w_issJVal = '0;
    w_issKVal = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_jVal[i] = '0;
      w_kVal[i] = '0;
    end
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (cdb_valid_in[c]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_tag_in[c*TAG_W +: TAG_W] == r_qj[i]) begin
            w_jHit[i] = 1'b1;
            w_jVal[i] = cdb_value_in[c*XLEN +: XLEN];
          end
          if (cdb_tag_in[c*TAG_W +: TAG_W] == r_qk[i]) begin
            w_kHit[i] = 1'b1;
            w_kVal[i] = cdb_value_in[c*XLEN +: XLEN];
          end
        end
        if (cdb_tag_in[c*TAG_W +: TAG_W] == issue_qj_in) begin
          w_issJHit = 1'b1;
          w_issJVal = cdb_value_in[c*XLEN +: XLEN];
        end
        if (cdb_tag_in[c*TAG_W +: TAG_W] == issue_qk_in) begin
          w_issKHit = 1'b1;
          w_issKVal = cdb_value_in[c*XLEN +: XLEN];
        end
      end
    end
  end

  // Entry storage: operand wake-up, freeing on dispatch and writing on issue
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy   <= '0;
      r_qjBusy <= '0;
      r_qkBusy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_dest[i] <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_op[i]   <= '0;
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
        r_imm[i]  <= '0;
      end
    end else if (flush_in) begin
      r_busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qjBusy[i] && w_jHit[i]) begin
          r_vj[i]     <= w_jVal[i];
          r_qjBusy[i] <= 1'b0;
        end
        if (r_busy[i] && r_qkBusy[i] && w_kHit[i]) begin
          r_vk[i]     <= w_kVal[i];
          r_qkBusy[i] <= 1'b0;
        end
      end
      if (w_dispatch) begin
        r_busy[w_selIdx] <= 1'b0;
      end
      if (w_issueAccept) begin
        r_busy[w_freeIdx]   <= 1'b1;
        r_op[w_freeIdx]     <= issue_op_in;
        r_inst[w_freeIdx]   <= issue_inst_in;
        r_pc[w_freeIdx]     <= issue_pc_in;
        r_imm[w_freeIdx]    <= issue_imm_in;
        r_dest[w_freeIdx]   <= issue_dest_in;
        r_qj[w_freeIdx]     <= issue_qj_in;
        r_qk[w_freeIdx]     <= issue_qk_in;
        r_qjBusy[w_freeIdx] <= issue_qj_busy_in & ~w_issJHit;
        r_qkBusy[w_freeIdx] <= issue_qk_busy_in & ~w_issKHit;
        r_vj[w_freeIdx]     <= (issue_qj_busy_in && w_issJHit) ? w_issJVal : issue_vj_in;
        r_vk[w_freeIdx]     <= (issue_qk_busy_in && w_issKHit) ? w_issKVal : issue_vk_in;
      end
    end
  end

  // Age matrix: a new entry is younger than every slot, and no slot is younger than it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_olderThan[i] <= '0;
      end
    end else if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_olderThan[i] <= '0;
      end
    end else if (rdy_in && w_issueAccept) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_olderThan[i][w_freeIdx] <= 1'b0;
      end
      r_olderThan[w_freeIdx] <= w_selfMask;
    end
  end

  // Occupancy counter tracks issues in and dispatch loads out
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (flush_in) begin
      r_count <= '0;
    end else if (rdy_in) begin
      r_count <= r_count + CNTW'(w_issueAccept) - CNTW'(w_dispatch);
    end
  end

  // Output stage: load the selected entry when empty or being consumed, else hold
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_execValid <= 1'b0;
      r_execOp    <= '0;
      r_execInst  <= '0;
      r_execPc    <= '0;
      r_execImm   <= '0;
      r_execDest  <= '0;
      r_execVj    <= '0;
      r_execVk    <= '0;
    end else if (flush_in) begin
      r_execValid <= 1'b0;
    end else if (rdy_in) begin
      if (w_dispatch) begin
        r_execValid <= 1'b1;
        r_execOp    <= r_op[w_selIdx];
        r_execInst  <= r_inst[w_selIdx];
        r_execPc    <= r_pc[w_selIdx];
        r_execImm   <= r_imm[w_selIdx];
        r_execDest  <= r_dest[w_selIdx];
        r_execVj    <= r_vj[w_selIdx];
        r_execVk    <= r_vk[w_selIdx];
      end else if (exec_ready_in) begin
        r_execValid <= 1'b0;
      end
    end
  end

  assign full_out       = w_full;
  assign count_out      = r_count;
  assign exec_valid_out = r_execValid;
  assign exec_op_out    = r_execOp;
  assign exec_inst_out  = r_execInst;
  assign exec_pc_out    = r_execPc;
  assign exec_imm_out   = r_execImm;
  assign exec_dest_out  = r_execDest;
  assign exec_vj_out    = r_execVj;
  assign exec_vk_out    = r_execVk;

endmodule

// File: tb/tb_alu_issue_station.sv
// Directed self-checking bench for alu_issue_station with default parameters.
module tb_alu_issue_station;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        issue_valid_in;
  logic [5:0]  issue_op_in;
  logic [31:0] issue_inst_in;
  logic [31:0] issue_pc_in;
  logic [31:0] issue_imm_in;
  logic [4:0]  issue_dest_in;
  logic [31:0] issue_vj_in;
  logic [31:0] issue_vk_in;
  logic        issue_qj_busy_in;
  logic        issue_qk_busy_in;
  logic [4:0]  issue_qj_in;
  logic [4:0]  issue_qk_in;
  logic [1:0]  cdb_valid_in;
  logic [9:0]  cdb_tag_in;
  logic [63:0] cdb_value_in;
  logic        exec_ready_in;
  logic        full_out;
  logic [4:0]  count_out;
  logic        exec_valid_out;
  logic [5:0]  exec_op_out;
  logic [31:0] exec_inst_out;
  logic [31:0] exec_pc_out;
  logic [31:0] exec_imm_out;
  logic [4:0]  exec_dest_out;
  logic [31:0] exec_vj_out;
  logic [31:0] exec_vk_out;

  int checkCount = 0;
  int errorCount = 0;

  alu_issue_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in),
    .issue_inst_in(issue_inst_in), .issue_pc_in(issue_pc_in),
    .issue_imm_in(issue_imm_in), .issue_dest_in(issue_dest_in),
    .issue_vj_in(issue_vj_in), .issue_vk_in(issue_vk_in),
    .issue_qj_busy_in(issue_qj_busy_in), .issue_qk_busy_in(issue_qk_busy_in),
    .issue_qj_in(issue_qj_in), .issue_qk_in(issue_qk_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
    .cdb_value_in(cdb_value_in), .exec_ready_in(exec_ready_in),
    .full_out(full_out), .count_out(count_out),
    .exec_valid_out(exec_valid_out), .exec_op_out(exec_op_out),
    .exec_inst_out(exec_inst_out), .exec_pc_out(exec_pc_out),
    .exec_imm_out(exec_imm_out), .exec_dest_out(exec_dest_out),
    .exec_vj_out(exec_vj_out), .exec_vk_out(exec_vk_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one issue slot; op/inst/pc/imm are derived from dest so they are checkable
  task automatic applyStimulus(input logic valid, input logic [4:0] dest,
                               input logic qjBusy, input logic [4:0] qj, input logic [31:0] vj,
                               input logic qkBusy, input logic [4:0] qk, input logic [31:0] vk);
    issue_valid_in   = valid;
    issue_dest_in    = dest;
    issue_op_in      = {1'b1, dest};
    issue_inst_in    = 32'h00000013 + 32'(dest);
    issue_pc_in      = 32'h00001000 + {25'd0, dest, 2'b00};
    issue_imm_in     = 32'(dest) * 3;
    issue_qj_busy_in = qjBusy;
    issue_qj_in      = qj;
    issue_vj_in      = vj;
    issue_qk_busy_in = qkBusy;
    issue_qk_in      = qk;
    issue_vk_in      = vk;
  endtask

  task automatic driveCdb(input logic [1:0] valid, input logic [4:0] tag0, input logic [31:0] val0,
                          input logic [4:0] tag1, input logic [31:0] val1);
    cdb_valid_in = valid;
    cdb_tag_in   = {tag1, tag0};
    cdb_value_in = {val1, val0};
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    driveCdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    flush_in      = 1'b0;
    exec_ready_in = 1'b1;
    idle();
    #12;
    rst_in = 1'b0;
    checkOutput("reset_count", 64'(count_out), 64'd0);
    checkOutput("reset_full", 64'(full_out), 64'd0);
    checkOutput("reset_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("reset_vj", 64'(exec_vj_out), 64'd0);

    // Ready-at-issue latency: visible two cycles after the issue cycle
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
    tick();
    idle();
    checkOutput("lat_n1_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("lat_n1_count", 64'(count_out), 64'd1);
    tick();
    checkOutput("lat_n2_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("lat_vj", 64'(exec_vj_out), 64'd5);
    checkOutput("lat_vk", 64'(exec_vk_out), 64'd7);
    checkOutput("lat_dest", 64'(exec_dest_out), 64'd3);
    checkOutput("lat_op", 64'(exec_op_out), 64'h23);
    checkOutput("lat_pc", 64'(exec_pc_out), 64'h100C);
    checkOutput("lat_imm", 64'(exec_imm_out), 64'd9);
    checkOutput("lat_inst", 64'(exec_inst_out), 64'h16);
    checkOutput("lat_count", 64'(count_out), 64'd0);
    tick();
    checkOutput("lat_drain", 64'(exec_valid_out), 64'd0);

    // Wake-up from CDB channel 1
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd2);
    tick();
    idle();
    checkOutput("wake_count", 64'(count_out), 64'd1);
    checkOutput("wake_wait0", 64'(exec_valid_out), 64'd0);
    tick();
    checkOutput("wake_wait1", 64'(exec_valid_out), 64'd0);
    driveCdb(2'b10, 5'd0, 32'd0, 5'd9, 32'hDEAD);
    tick();
    idle();
    checkOutput("wake_cap", 64'(exec_valid_out), 64'd0);
    tick();
    checkOutput("wake_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("wake_vj", 64'(exec_vj_out), 64'hDEAD);
    checkOutput("wake_vk", 64'(exec_vk_out), 64'd2);
    checkOutput("wake_dest", 64'(exec_dest_out), 64'd4);
    tick();

    // Issue-time forwarding: stored ready, so normal two-cycle latency
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd3);
    driveCdb(2'b01, 5'd9, 32'h1234, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("fwd_n1", 64'(exec_valid_out), 64'd0);
    tick();
    checkOutput("fwd_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("fwd_vj", 64'(exec_vj_out), 64'h1234);
    tick();

    // Duplicate tag on both channels: channel 0 value is taken
    applyStimulus(1'b1, 5'd6, 1'b0, 5'd0, 32'd8, 1'b1, 5'd6, 32'd0);
    tick();
    idle();
    driveCdb(2'b11, 5'd6, 32'hAAA, 5'd6, 32'hBBB);
    tick();
    idle();
    tick();
    checkOutput("dup_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("dup_vk", 64'(exec_vk_out), 64'hAAA);
    tick();

    // Fill every slot with waiting entries, then drain in issue order
    exec_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'(i), 1'b1, 5'd20, 32'd0, 1'b0, 5'd0, 32'(100 + i));
      tick();
    end
    checkOutput("fill_count", 64'(count_out), 64'd16);
    checkOutput("fill_full", 64'(full_out), 64'd1);
    applyStimulus(1'b1, 5'd31, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd999);
    tick();
    idle();
    checkOutput("drop_count", 64'(count_out), 64'd16);
    checkOutput("drop_full", 64'(full_out), 64'd1);
    driveCdb(2'b01, 5'd20, 32'd77, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("fill_cap", 64'(exec_valid_out), 64'd0);
    tick();
    exec_ready_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput("drain_valid", 64'(exec_valid_out), 64'd1);
      checkOutput("drain_dest", 64'(exec_dest_out), 64'(k));
      checkOutput("drain_vk", 64'(exec_vk_out), 64'(100 + k));
      checkOutput("drain_vj", 64'(exec_vj_out), 64'd77);
      checkOutput("drain_count", 64'(count_out), 64'(15 - k));
      tick();
    end
    checkOutput("drain_end_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("drain_end_count", 64'(count_out), 64'd0);

    // Older waiting A, younger ready B: B goes first, A after wake-up
    applyStimulus(1'b1, 5'd10, 1'b1, 5'd4, 32'd0, 1'b0, 5'd0, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd11, 1'b0, 5'd0, 32'd2, 1'b0, 5'd0, 32'd3);
    tick();
    idle();
    checkOutput("ab_none", 64'(exec_valid_out), 64'd0);
    tick();
    checkOutput("ab_first_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("ab_first_dest", 64'(exec_dest_out), 64'd11);
    driveCdb(2'b01, 5'd4, 32'd55, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("ab_gap", 64'(exec_valid_out), 64'd0);
    tick();
    checkOutput("ab_second_dest", 64'(exec_dest_out), 64'd10);
    checkOutput("ab_second_vj", 64'(exec_vj_out), 64'd55);
    tick();
    checkOutput("ab_drain", 64'(exec_valid_out), 64'd0);

    // Older Y sits in slot 1, younger Z reuses slot 0; both wake together
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd7, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd8, 32'd0, 1'b0, 5'd0, 32'd0);
    driveCdb(2'b01, 5'd7, 32'h70, 5'd0, 32'd0);
    tick();
    idle();
    tick();
    checkOutput("age_x_dest", 64'(exec_dest_out), 64'd1);
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd8, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("age_gap", 64'(exec_valid_out), 64'd0);
    driveCdb(2'b01, 5'd8, 32'h80, 5'd0, 32'd0);
    tick();
    idle();
    tick();
    checkOutput("age_y_first", 64'(exec_dest_out), 64'd2);
    tick();
    checkOutput("age_z_second", 64'(exec_dest_out), 64'd3);
    checkOutput("age_z_vj", 64'(exec_vj_out), 64'h80);
    tick();
    checkOutput("age_drain", 64'(exec_valid_out), 64'd0);
    checkOutput("age_count", 64'(count_out), 64'd0);

    // Stall, freeze with rdy low, then flush with rdy still low
    exec_ready_in = 1'b0;
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd13, 1'b0, 5'd0, 32'd2, 1'b0, 5'd0, 32'd2);
    tick();
    idle();
    tick();
    checkOutput("stall_count", 64'(count_out), 64'd1);
    checkOutput("stall_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("stall_dest", 64'(exec_dest_out), 64'd12);
    rdy_in        = 1'b0;
    exec_ready_in = 1'b1;
    applyStimulus(1'b1, 5'd14, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd3);
    driveCdb(2'b11, 5'd1, 32'd1, 5'd2, 32'd2);
    tick();
    idle();
    checkOutput("freeze_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("freeze_dest", 64'(exec_dest_out), 64'd12);
    checkOutput("freeze_count", 64'(count_out), 64'd1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    rdy_in   = 1'b1;
    checkOutput("flush_count", 64'(count_out), 64'd0);
    checkOutput("flush_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("flush_full", 64'(full_out), 64'd0);
    tick();
    checkOutput("flush_gone", 64'(exec_valid_out), 64'd0);

    // Asynchronous reset asserted between edges while an entry is held at the output
    exec_ready_in = 1'b0;
    applyStimulus(1'b1, 5'd14, 1'b0, 5'd0, 32'h66, 1'b0, 5'd0, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd15, 1'b0, 5'd0, 32'h67, 1'b0, 5'd0, 32'd1);
    tick();
    idle();
    tick();
    checkOutput("pre_rst_valid", 64'(exec_valid_out), 64'd1);
    checkOutput("pre_rst_count", 64'(count_out), 64'd1);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("async_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("async_vj", 64'(exec_vj_out), 64'd0);
    checkOutput("async_dest", 64'(exec_dest_out), 64'd0);
    checkOutput("async_count", 64'(count_out), 64'd0);
    #2;
    rst_in = 1'b0;
    tick();
    checkOutput("post_rst_valid", 64'(exec_valid_out), 64'd0);
    checkOutput("post_rst_count", 64'(count_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_station.md
ALU_ISSUE_STATION -- requirements
Module: alu_issue_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16, entry count (power of two, 2..64).
REQ-002 SHALL have parameter XLEN, default 32, operand width.
REQ-003 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-004 SHALL have parameter CDB_N, default 2, number of broadcast channels (ch0 ALU, ch1 LSB).
REQ-005 SHALL have ports, in this order:
- clk_in  input  1  single clock; rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  low = pause, all state frozen.
- flush_in  input  1  mispredict roll-back.
- issue_valid_in  input  1  new instruction offered.
- issue_op_in  input  6  decoded op type.
- issue_inst_in  input  32  raw instruction.
- issue_pc_in  input  32  instruction PC.
- issue_imm_in  input  32  immediate.
- issue_dest_in  input  TAG_W  destination ROB tag.
- issue_vj_in / issue_vk_in  input  XLEN  operand values.
- issue_qj_busy_in / issue_qk_busy_in  input  1  operand pending.
- issue_qj_in / issue_qk_in  input  TAG_W  producer tags.
- cdb_valid_in  input  CDB_N  per-channel broadcast valid.
- cdb_tag_in  input  CDB_N*TAG_W  packed tags, ch0 in LSBs.
- cdb_value_in  input  CDB_N*XLEN  packed values.
- exec_ready_in  input  1  ALU accepts.
- full_out  output  1  no free entry.
- count_out  output  clog2(RS_SIZE)+1  occupied entries.
- exec_valid_out  output  1  dispatch valid.
- exec_op_out, exec_inst_out, exec_pc_out, exec_imm_out, exec_dest_out, exec_vj_out, exec_vk_out  output  as issue_*  dispatched fields.

Function
REQ-006 Entry state SHALL be busy, qj_busy, qk_busy, stored fields; ready = busy & !qj_busy & !qk_busy.
REQ-007 Issue SHALL be accepted when issue_valid_in & !full_out & rdy_in & !flush_in; written into lowest-index free entry; ignored when full_out=1.
REQ-008 At issue, an operand whose tag matches a same-cycle valid CDB channel SHALL be stored with that value and busy cleared (issue-time forwarding).
REQ-009 Each cycle, every busy entry's pending operand matching a valid CDB channel SHALL capture the value and clear its busy bit; lowest channel index wins on duplicate tags.
REQ-010 An entry SHALL become dispatch-eligible the cycle after its last operand is captured.
REQ-011 Selection SHALL be oldest-first among ready entries by issue order (age matrix), independent of slot index.
REQ-012 Output register SHALL load the selected entry and free it when (!exec_valid_out | exec_ready_in) and a ready entry exists; exec_valid_out cleared when exec_ready_in=1 and nothing ready.
REQ-013 While exec_valid_out=1 and exec_ready_in=0, all exec_* outputs SHALL hold stable.
REQ-014 Latency: issue with both operands ready in cycle N SHALL give exec_valid_out=1 in cycle N+2 (output stage empty).
REQ-015 count_out SHALL be a register: +1 on issue, -1 on dispatch load, unchanged on both; full_out = (count_out == RS_SIZE), registered-state based, so issue is rejected in a full cycle even if dispatch frees a slot.
REQ-016 A freed slot SHALL be reusable from the following cycle.
REQ-017 flush_in SHALL, regardless of rdy_in, on next edge clear all busy bits, exec_valid_out, count_out and age state; overrides issue, wake-up and dispatch in that cycle.
REQ-018 rdy_in=0 (no flush) SHALL freeze all state including outputs; CDB inputs ignored.

Reset
REQ-019 rst_in=1 SHALL asynchronously clear all busy bits, age state, count_out=0, full_out=0, exec_valid_out=0 and all exec_* data outputs to 0.
REQ-020 Release of rst_in SHALL take effect on the next clock edge with no further initialisation cycles.

Verification
REQ-021 Issue op with both operands ready (vj=5, vk=7, dest=3), exec_ready_in=1 -> exec_valid_out=1 two cycles later, vj=5, vk=7, dest=3, count returns 0.
REQ-022 Issue with qj_busy, qj=9; later cdb ch1 tag=9 value=0xDEAD -> dispatch next-but-one cycle with vj=0xDEAD; same-cycle tag=9 at issue -> entry stored ready.
REQ-023 Fill RS_SIZE entries with exec_ready_in=0 -> full_out=1, count=RS_SIZE, 17th issue dropped; release -> entries dispatched in issue order.
REQ-024 Issue A (waiting tag 4) then B (ready); wake A -> B dispatched before A only if B ready earlier; both ready -> A (older) first.
REQ-025 Entries busy, exec_valid_out=1, assert flush_in with rdy_in=0 -> next cycle count=0, exec_valid_out=0, full_out=0.
REQ-026 Assert rst_in mid-dispatch between clock edges -> outputs cleared immediately, without waiting for clock.
